// File: rtl/mem_issue_queue.sv
// mem_issue_queue
//   Small memory-op issue queue feeding the AGU. Holds DEPTH micro-ops,
//   tracks source readiness from the writeback bus, drops entries on branch
//   kill, and issues one ready entry per cycle into a registered packet.
//
//   Optional build macro: MEM_IQ_AGE_ORDER_EN
//     defined   -> oldest issuable entry is selected (per-entry age count)
//     undefined -> lowest-index issuable entry is selected
//
// Ports
//   i_clk, i_rst_n        clock, async active-low reset
//   i_val / o_ready       enqueue handshake (o_ready = queue not full)
//   i_uop .. i_imm        micro-op payload
//   i_rs1/i_rs2           source register addresses
//   i_rdy1/i_rdy2         source already available, value on i_op1/i_op2
//   i_wb_val/addr/data    writeback wakeup bus
//   i_brkill              mispredicted branch vector
//   o_instr               {val[1:0], uop, tag, brmask, rd, func, imm, op2, op1}
module mem_issue_queue #(
    parameter int WIDTH_REG = 5,
    parameter int WIDTH_BRM = 4,
    parameter int WIDTH_TAG = 4,
    parameter int WIDTH_IQ  = 2,
    localparam int NUM_BR   = 2**WIDTH_BRM,
    localparam int DEPTH    = 2**WIDTH_IQ,
    localparam int WIDTH    = 2 + 7 + WIDTH_TAG + NUM_BR + WIDTH_REG + 10 + 96
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_val,
    output logic                 o_ready,
    input  logic [6:0]           i_uop,
    input  logic [WIDTH_TAG-1:0] i_tag,
    input  logic [NUM_BR-1:0]    i_brmask,
    input  logic [WIDTH_REG-1:0] i_rd,
    input  logic [9:0]           i_func,
    input  logic [31:0]          i_imm,
    input  logic [WIDTH_REG-1:0] i_rs1,
    input  logic [WIDTH_REG-1:0] i_rs2,
    input  logic                 i_rdy1,
    input  logic                 i_rdy2,
    input  logic [31:0]          i_op1,
    input  logic [31:0]          i_op2,
    input  logic                 i_wb_val,
    input  logic [WIDTH_REG-1:0] i_wb_addr,
    input  logic [31:0]          i_wb_data,
    input  logic [NUM_BR-1:0]    i_brkill,
    output logic [WIDTH-1:0]     o_instr
);

    localparam logic [6:0] UOP_LOAD  = 7'b0000011;
    localparam logic [6:0] UOP_STORE = 7'b0100011;

    logic [DEPTH-1:0]     ent_val;
    logic [DEPTH-1:0]     ent_rdy1;
    logic [DEPTH-1:0]     ent_rdy2;
    logic [6:0]           ent_uop    [DEPTH];
    logic [WIDTH_TAG-1:0] ent_tag    [DEPTH];
    logic [NUM_BR-1:0]    ent_brmask [DEPTH];
    logic [WIDTH_REG-1:0] ent_rd     [DEPTH];
    logic [9:0]           ent_func   [DEPTH];
    logic [31:0]          ent_imm    [DEPTH];
    logic [WIDTH_REG-1:0] ent_rs1    [DEPTH];
    logic [WIDTH_REG-1:0] ent_rs2    [DEPTH];
    logic [31:0]          ent_op1    [DEPTH];
    logic [31:0]          ent_op2    [DEPTH];
`ifdef MEM_IQ_AGE_ORDER_EN
    logic [WIDTH_IQ:0]    ent_age    [DEPTH];
    logic [WIDTH_IQ:0]    best_age;
`endif

    logic                 wb_hit;
    logic [DEPTH-1:0]     killed;
    logic [DEPTH-1:0]     issuable;
    logic [DEPTH-1:0]     wake1;
    logic [DEPTH-1:0]     wake2;
    logic                 sel_any;
    logic [DEPTH-1:0]     sel_oh;
    logic [WIDTH_IQ-1:0]  sel_idx;
    logic [1:0]           sel_class;
    logic [WIDTH-1:0]     instr_d;
    logic                 enq_acc;
    logic                 enq_wr;
    logic [WIDTH_IQ-1:0]  enq_idx;
    logic                 enq_rdy1;
    logic                 enq_rdy2;
    logic [31:0]          enq_op1;
    logic [31:0]          enq_op2;

    // Register 0 is hardwired zero, so it never produces a wakeup.
    assign wb_hit  = i_wb_val && (i_wb_addr != '0);
    assign o_ready = ~&ent_val;
    assign enq_acc = i_val && o_ready;
    assign enq_wr  = enq_acc && ((i_brmask & i_brkill) == '0);

    always_comb begin
        killed   = '0;
        issuable = '0;
        wake1    = '0;
        wake2    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            killed[i]   = |(ent_brmask[i] & i_brkill);
            issuable[i] = ent_val[i] && !killed[i] && ent_rdy1[i] &&
                          ((ent_uop[i] != UOP_STORE) || ent_rdy2[i]);
            wake1[i]    = ent_val[i] && wb_hit && !ent_rdy1[i] && (ent_rs1[i] == i_wb_addr);
            wake2[i]    = ent_val[i] && wb_hit && !ent_rdy2[i] && (ent_rs2[i] == i_wb_addr);
        end
    end

    // Strict compare keeps the lowest index on an age tie.
    always_comb begin
        sel_any = 1'b0;
        sel_idx = '0;
        sel_oh  = '0;
`ifdef MEM_IQ_AGE_ORDER_EN
        best_age = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
`ifdef MEM_IQ_AGE_ORDER_EN
            if (issuable[i] && (!sel_any || (ent_age[i] > best_age))) begin
                best_age = ent_age[i];
`else
            if (issuable[i] && !sel_any) begin
`endif
                sel_any = 1'b1;
                sel_idx = WIDTH_IQ'(i);
            end
        end
        if (sel_any) begin
            sel_oh[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_class = 2'b00;
        if (ent_uop[sel_idx] == UOP_LOAD) begin
            sel_class = 2'b01;
        end else if (ent_uop[sel_idx] == UOP_STORE) begin
            sel_class = 2'b11;
        end
        instr_d = '0;
        if (sel_any) begin
            instr_d = {sel_class, ent_uop[sel_idx], ent_tag[sel_idx], ent_brmask[sel_idx],
                       ent_rd[sel_idx], ent_func[sel_idx], ent_imm[sel_idx],
                       ent_op2[sel_idx], ent_op1[sel_idx]};
        end
    end

    // Lowest free slot: scan downwards so the lowest index is written last.
    always_comb begin
        enq_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_val[i]) begin
                enq_idx = WIDTH_IQ'(i);
            end
        end
    end

    // Source capture at enqueue: r0 forces zero, otherwise a same-cycle
    // writeback is folded in so the entry never misses its wakeup.
    always_comb begin
        enq_rdy1 = i_rdy1;
        enq_op1  = i_op1;
        enq_rdy2 = i_rdy2;
        enq_op2  = i_op2;
        if (i_rs1 == '0) begin
            enq_rdy1 = 1'b1;
            enq_op1  = '0;
        end else if (!i_rdy1 && wb_hit && (i_wb_addr == i_rs1)) begin
            enq_rdy1 = 1'b1;
            enq_op1  = i_wb_data;
        end
        if (i_rs2 == '0) begin
            enq_rdy2 = 1'b1;
            enq_op2  = '0;
        end else if (!i_rdy2 && wb_hit && (i_wb_addr == i_rs2)) begin
            enq_rdy2 = 1'b1;
            enq_op2  = i_wb_data;
        end
    end

    // The enqueue slot is always currently free, so it never collides with
    // the kill/issue clears of a live entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ent_val <= '0;
            o_instr <= '0;
        end else begin
            o_instr <= instr_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (killed[i] || sel_oh[i]) begin
                    ent_val[i] <= 1'b0;
                end
            end
            if (enq_wr) begin
                ent_val[enq_idx] <= 1'b1;
            end
        end
    end

    // Payload is qualified by ent_val everywhere, so it carries no reset.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wake1[i]) begin
                ent_rdy1[i] <= 1'b1;
                ent_op1[i]  <= i_wb_data;
            end
            if (wake2[i]) begin
                ent_rdy2[i] <= 1'b1;
                ent_op2[i]  <= i_wb_data;
            end
`ifdef MEM_IQ_AGE_ORDER_EN
            if (enq_acc && (ent_age[i] != '1)) begin
                ent_age[i] <= ent_age[i] + 1'b1;
            end
`endif
        end
        if (enq_wr) begin
            ent_uop[enq_idx]    <= i_uop;
            ent_tag[enq_idx]    <= i_tag;
            ent_brmask[enq_idx] <= i_brmask;
            ent_rd[enq_idx]     <= i_rd;
            ent_func[enq_idx]   <= i_func;
            ent_imm[enq_idx]    <= i_imm;
            ent_rs1[enq_idx]    <= i_rs1;
            ent_rs2[enq_idx]    <= i_rs2;
            ent_rdy1[enq_idx]   <= enq_rdy1;
            ent_rdy2[enq_idx]   <= enq_rdy2;
            ent_op1[enq_idx]    <= enq_op1;
            ent_op2[enq_idx]    <= enq_op2;
`ifdef MEM_IQ_AGE_ORDER_EN
            ent_age[enq_idx]    <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Testbench for mem_issue_queue: vector table, directed multi-cycle
// sequences and a randomized run against a behavioural queue model.
module tb_mem_issue_queue;

    localparam int WIDTH_REG = 5;
    localparam int WIDTH_BRM = 4;
    localparam int WIDTH_TAG = 4;
    localparam int WIDTH_IQ  = 2;
    localparam int NBR       = 16;
    localparam int DEPTH     = 4;
    localparam int W         = 2 + 7 + WIDTH_TAG + NBR + WIDTH_REG + 10 + 96;
    localparam int AGE_MAX   = 2**(WIDTH_IQ + 1) - 1;
`ifdef MEM_IQ_AGE_ORDER_EN
    localparam bit AGE_MODE  = 1'b1;
`else
    localparam bit AGE_MODE  = 1'b0;
`endif
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] OT = 7'b0110011;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          val = 1'b0;
    logic          ready;
    logic [6:0]    uop = '0;
    logic [3:0]    tag = '0;
    logic [15:0]   brmask = '0;
    logic [4:0]    rd = '0;
    logic [9:0]    func = '0;
    logic [31:0]   imm = '0;
    logic [4:0]    rs1 = '0;
    logic [4:0]    rs2 = '0;
    logic          rdy1 = 1'b0;
    logic          rdy2 = 1'b0;
    logic [31:0]   op1 = '0;
    logic [31:0]   op2 = '0;
    logic          wb_val = 1'b0;
    logic [4:0]    wb_addr = '0;
    logic [31:0]   wb_data = '0;
    logic [15:0]   brkill = '0;
    logic [W-1:0]  instr;

    int n_pass = 0;
    int n_total = 0;

    mem_issue_queue #(
        .WIDTH_REG(WIDTH_REG), .WIDTH_BRM(WIDTH_BRM),
        .WIDTH_TAG(WIDTH_TAG), .WIDTH_IQ(WIDTH_IQ)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_val(val), .o_ready(ready),
        .i_uop(uop), .i_tag(tag), .i_brmask(brmask), .i_rd(rd), .i_func(func),
        .i_imm(imm), .i_rs1(rs1), .i_rs2(rs2), .i_rdy1(rdy1), .i_rdy2(rdy2),
        .i_op1(op1), .i_op2(op2), .i_wb_val(wb_val), .i_wb_addr(wb_addr),
        .i_wb_data(wb_data), .i_brkill(brkill), .o_instr(instr)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", name, act, exp);
    endtask

    function automatic logic [1:0] op_class(input logic [6:0] u);
        if (u == LD) return 2'b01;
        if (u == ST) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [W-1:0] pkt(input logic [6:0] u, input logic [3:0] t,
            input logic [15:0] bm, input logic [4:0] r, input logic [9:0] fn,
            input logic [31:0] im, input logic [31:0] o2, input logic [31:0] o1);
        return {op_class(u), u, t, bm, r, fn, im, o2, o1};
    endfunction

    // Directed enqueues derive rd/func from the tag so expectations can too.
    function automatic logic [W-1:0] dpkt(input logic [6:0] u, input logic [3:0] t,
            input logic [15:0] bm, input logic [31:0] im, input logic [31:0] o2, input logic [31:0] o1);
        return pkt(u, t, bm, {1'b1, t}, {6'h2A, t}, im, o2, o1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        val = 1'b0;
        wb_val = 1'b0;
        brkill = '0;
    endtask

    task automatic drive_enq(input logic [6:0] u, input logic [3:0] t, input logic [15:0] bm,
            input logic [4:0] s1, input logic [4:0] s2, input logic r1, input logic r2,
            input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] im);
        val = 1'b1; uop = u; tag = t; brmask = bm; rd = {1'b1, t}; func = {6'h2A, t};
        rs1 = s1; rs2 = s2; rdy1 = r1; rdy2 = r2; op1 = o1; op2 = o2; imm = im;
    endtask

    task automatic wake(input logic [4:0] a, input logic [31:0] d);
        wb_val = 1'b1; wb_addr = a; wb_data = d;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit          v;
        logic [6:0]  uop;
        logic [3:0]  tag;
        logic [15:0] bm;
        logic [4:0]  rd;
        logic [9:0]  fn;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2;
        bit          r1, r2;
        logic [31:0] o1, o2;
        int          stamp;
    } ment_t;

    ment_t m[DEPTH];
    int    g_acc;

    function automatic bit model_ready();
        for (int i = 0; i < DEPTH; i++) if (!m[i].v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
        g_acc = 0;
    endtask

    task automatic model_step(output logic [W-1:0] exp);
        int sel, best, age, free;
        bit rdy_now, wb;
        rdy_now = model_ready();
        wb = wb_val && (wb_addr != 0);
        sel = -1; best = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i].v && ((m[i].bm & brkill) == 0) && m[i].r1 && (m[i].uop != ST || m[i].r2)) begin
                age = g_acc - m[i].stamp;
                if (age > AGE_MAX) age = AGE_MAX;
                if (AGE_MODE) begin
                    if (age > best) begin best = age; sel = i; end
                end else if (sel < 0) sel = i;
            end
        end
        exp = '0;
        if (sel >= 0)
            exp = pkt(m[sel].uop, m[sel].tag, m[sel].bm, m[sel].rd, m[sel].fn,
                      m[sel].imm, m[sel].o2, m[sel].o1);
        free = -1;
        for (int i = 0; i < DEPTH; i++) if (!m[i].v && free < 0) free = i;
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i].v) begin
                if (((m[i].bm & brkill) != 0) || i == sel) m[i].v = 1'b0;
                else begin
                    if (!m[i].r1 && wb && m[i].rs1 == wb_addr) begin m[i].r1 = 1'b1; m[i].o1 = wb_data; end
                    if (!m[i].r2 && wb && m[i].rs2 == wb_addr) begin m[i].r2 = 1'b1; m[i].o2 = wb_data; end
                end
            end
        end
        if (val && rdy_now) begin
            g_acc++;
            if ((brmask & brkill) == 0) begin
                m[free].v = 1'b1; m[free].uop = uop; m[free].tag = tag; m[free].bm = brmask;
                m[free].rd = rd; m[free].fn = func; m[free].imm = imm;
                m[free].rs1 = rs1; m[free].rs2 = rs2; m[free].stamp = g_acc;
                if (rs1 == 0) begin m[free].r1 = 1'b1; m[free].o1 = '0; end
                else if (rdy1) begin m[free].r1 = 1'b1; m[free].o1 = op1; end
                else if (wb && wb_addr == rs1) begin m[free].r1 = 1'b1; m[free].o1 = wb_data; end
                else begin m[free].r1 = 1'b0; m[free].o1 = op1; end
                if (rs2 == 0) begin m[free].r2 = 1'b1; m[free].o2 = '0; end
                else if (rdy2) begin m[free].r2 = 1'b1; m[free].o2 = op2; end
                else if (wb && wb_addr == rs2) begin m[free].r2 = 1'b1; m[free].o2 = wb_data; end
                else begin m[free].r2 = 1'b0; m[free].o2 = op2; end
            end
        end
    endtask

    // ---------------- single-entry vector table ----------------
    typedef struct {
        logic [6:0]  uop;
        logic [4:0]  rs1, rs2;
        logic        rdy1, rdy2;
        logic [31:0] op1, op2, imm;
        bit          exp_issue;
        logic [31:0] exp_op1, exp_op2;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [W-1:0] exp_i, first_p, second_p, pa, pb;
        vt[0] = '{LD, 5'd3, 5'd4, 1'b1, 1'b0, 32'h100, 32'h55, 32'h4, 1'b1, 32'h100, 32'h55};
        vt[1] = '{ST, 5'd3, 5'd4, 1'b1, 1'b1, 32'hA0,  32'hB0, 32'h8, 1'b1, 32'hA0,  32'hB0};
        vt[2] = '{ST, 5'd3, 5'd5, 1'b1, 1'b0, 32'hA1,  32'hB1, 32'h0, 1'b0, 32'h0,   32'h0};
        vt[3] = '{OT, 5'd2, 5'd6, 1'b1, 1'b0, 32'h7,   32'h9,  32'hC, 1'b1, 32'h7,   32'h9};
        vt[4] = '{LD, 5'd0, 5'd6, 1'b0, 1'b0, 32'hFFFF, 32'h1, 32'h10, 1'b1, 32'h0,  32'h1};
        vt[5] = '{LD, 5'd3, 5'd0, 1'b0, 1'b0, 32'h3,   32'h4,  32'h0, 1'b0, 32'h0,   32'h0};
        vt[6] = '{ST, 5'd0, 5'd0, 1'b0, 1'b0, 32'h11,  32'h22, 32'h14, 1'b1, 32'h0,  32'h0};
        vt[7] = '{ST, 5'd2, 5'd0, 1'b1, 1'b1, 32'h33,  32'h77, 32'h18, 1'b1, 32'h33, 32'h0};

        do_reset();
        check_bit("reset_ready", ready, 1'b1);
        check_vec("reset_instr", instr, '0);

        for (int k = 0; k < 8; k++) begin
            do_reset();
            drive_enq(vt[k].uop, 4'(k), 16'h0, vt[k].rs1, vt[k].rs2, vt[k].rdy1, vt[k].rdy2,
                      vt[k].op1, vt[k].op2, vt[k].imm);
            step();
            idle();
            check_vec($sformatf("vec%0d_enq", k), instr, '0);
            step();
            exp_i = vt[k].exp_issue ? dpkt(vt[k].uop, 4'(k), 16'h0, vt[k].imm, vt[k].exp_op2, vt[k].exp_op1) : '0;
            check_vec($sformatf("vec%0d_issue", k), instr, exp_i);
            step();
            check_vec($sformatf("vec%0d_after", k), instr, '0);
        end

        // store waiting on rs2, woken by writeback
        do_reset();
        drive_enq(ST, 4'h2, 16'h0, 5'd6, 5'd5, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
        step(); idle(); step();
        check_vec("st_wait", instr, '0);
        wake(5'd5, 32'hDEAD);
        step(); idle();
        check_vec("st_wake_edge", instr, '0);
        step();
        check_vec("st_issue", instr, dpkt(ST, 4'h2, 16'h0, 32'h0, 32'hDEAD, 32'h10));
        step();
        check_vec("st_after", instr, '0);

        // fill, drop fifth, issue one, ready returns
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_enq(LD, 4'(k), 16'h0, 5'(k + 1), 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'(k));
            step();
        end
        idle();
        check_bit("full_ready", ready, 1'b0);
        drive_enq(LD, 4'h9, 16'h0, 5'd1, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h9);
        step(); idle();
        check_bit("full_drop_ready", ready, 1'b0);
        wake(5'd3, 32'h333);
        step(); idle();
        check_bit("full_no_bypass", ready, 1'b0);
        step();
        check_vec("full_issue", instr, dpkt(LD, 4'h2, 16'h0, 32'h2, 32'h0, 32'h333));
        check_bit("full_ready_back", ready, 1'b1);
        wake(5'd1, 32'h111);
        step(); idle(); step();
        check_vec("full_next", instr, dpkt(LD, 4'h0, 16'h0, 32'h0, 32'h0, 32'h111));

        // branch kill with simultaneous wakeup
        do_reset();
        drive_enq(LD, 4'h1, 16'h0002, 5'd1, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        drive_enq(LD, 4'h2, 16'h0004, 5'd1, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step(); idle();
        brkill = 16'h0002;
        wake(5'd1, 32'hBEEF);
        step(); idle();
        check_vec("kill_edge", instr, '0);
        step();
        check_vec("kill_survivor", instr, dpkt(LD, 4'h2, 16'h0004, 32'h0, 32'h0, 32'hBEEF));
        step();
        check_vec("kill_none1", instr, '0);
        step();
        check_vec("kill_none2", instr, '0);

        // A in entry 1, B in entry 0, both ready together
        do_reset();
        drive_enq(LD, 4'h5, 16'h0001, 5'd1, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        drive_enq(LD, 4'hA, 16'h0000, 5'd2, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hA);
        step(); idle();
        brkill = 16'h0001;
        step(); idle();
        drive_enq(LD, 4'hB, 16'h0000, 5'd2, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hB);
        step(); idle();
        wake(5'd2, 32'h222);
        step(); idle();
        pa = dpkt(LD, 4'hA, 16'h0, 32'hA, 32'h0, 32'h222);
        pb = dpkt(LD, 4'hB, 16'h0, 32'hB, 32'h0, 32'h222);
`ifdef MEM_IQ_AGE_ORDER_EN
        first_p = pa; second_p = pb;
`else
        first_p = pb; second_p = pa;
`endif
        step();
        check_vec("order_first", instr, first_p);
        step();
        check_vec("order_second", instr, second_p);
        step();
        check_vec("order_done", instr, '0);

        // async reset mid-cycle with live entries and a packet in o_instr
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive_enq(LD, 4'(k), 16'h0, 5'd1, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
            step();
        end
        drive_enq(LD, 4'h7, 16'h0, 5'd2, 5'd0, 1'b1, 1'b0, 32'h77, 32'h0, 32'h70);
        step(); idle();
        check_bit("rst_full", ready, 1'b0);
        step();
        check_vec("rst_pre", instr, dpkt(LD, 4'h7, 16'h0, 32'h70, 32'h0, 32'h77));
        #2 rst_n = 1'b0;
        #1;
        check_vec("rst_instr", instr, '0);
        check_bit("rst_ready", ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wake(5'd1, 32'h5A5A);
        for (int k = 0; k < 3; k++) begin
            step();
            check_vec($sformatf("rst_no_issue%0d", k), instr, '0);
        end
        idle();

        // randomized run against the reference model
        do_reset();
        model_clear();
        exp_i = '0;
        for (int c = 0; c < 500; c++) begin
            check_bit("rnd_ready", ready, model_ready());
            val     = ($urandom_range(9, 0) < 6);
            case ($urandom_range(2, 0))
                0: uop = LD;
                1: uop = ST;
                default: uop = 7'($urandom);
            endcase
            tag     = 4'($urandom);
            brmask  = ($urandom_range(3, 0) == 0) ? 16'h0 : 16'(1 << $urandom_range(3, 0));
            rd      = 5'($urandom);
            func    = 10'($urandom);
            imm     = $urandom;
            rs1     = 5'($urandom_range(3, 0));
            rs2     = 5'($urandom_range(3, 0));
            rdy1    = ($urandom_range(2, 0) == 0);
            rdy2    = ($urandom_range(2, 0) == 0);
            op1     = $urandom;
            op2     = $urandom;
            wb_val  = 1'($urandom);
            wb_addr = 5'($urandom_range(3, 0));
            wb_data = $urandom;
            brkill  = ($urandom_range(7, 0) == 0) ? 16'(1 << $urandom_range(3, 0)) : 16'h0;
            model_step(exp_i);
            step();
            check_vec($sformatf("rnd_instr_c%0d", c), instr, exp_i);
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
